// File: rtl/obstacle_scroller_pkg.sv
// Shared types and constants for the obstacle scroller block.
package obstacle_pkg;

  // Frame-update sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_NEXT,
    S_SPAWN,
    S_SPDRAW,
    S_DONE
  } state_t;

  // Spawn-row LFSR: 10-bit Fibonacci, x^10 + x^7 + 1 (maximal length)
  localparam int LFSR_W     = 10;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

  // Draw command fields are sized for the widest supported configuration;
  // the top narrows them to its own X_W/Y_W/id width on the way out.
  localparam int CMD_X_W  = 16;
  localparam int CMD_Y_W  = 16;
  localparam int CMD_ID_W = 3;

  typedef struct packed {
    logic [CMD_X_W-1:0]  x;
    logic [CMD_Y_W-1:0]  y;
    logic                erase;
    logic [CMD_ID_W-1:0] id;
  } draw_cmd_t;

  // Fold a raw random value into [0, y_max): one subtraction, and anything
  // still out of range collapses to row 0.
  function automatic int unsigned fold_y(input int unsigned r,
                                         input int unsigned y_max);
    if (r < y_max)
      return r;
    if (r - y_max < y_max)
      return r - y_max;
    return 0;
  endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// Draw-command port between the scroller and the single-sprite drawer.
interface obstacle_scroller_if #(
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int ID_W = 2
);
  logic            draw_req;
  logic            draw_ack;
  logic [X_W-1:0]  draw_x;
  logic [Y_W-1:0]  draw_y;
  logic            draw_erase;
  logic [ID_W-1:0] draw_id;

  // Scroller side issues commands
  modport master (
    output draw_req, draw_x, draw_y, draw_erase, draw_id,
    input  draw_ack
  );

  // Drawer side accepts them
  modport slave (
    input  draw_req, draw_x, draw_y, draw_erase, draw_id,
    output draw_ack
  );
endinterface

// File: rtl/obstacle_lfsr.sv
// Free-running 10-bit Fibonacci LFSR supplying spawn rows.
module obstacle_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 10'h094,
  parameter int                OUT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] q;

  // Shift every clock; a nonzero seed keeps it off the all-zero lockup state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= SEED;
    else
      q <= {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  end

  assign rnd = q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scroller.sv
// Multi-object right-to-left scroller: per frame tick, erase/move/redraw
// every active slot, then spawn a new object when the spawn gap expires.
module obstacle_scroller
  import obstacle_pkg::*;
#(
  parameter int                N_OBJ     = 4,
  parameter int                X_W       = 8,
  parameter int                Y_W       = 7,
  parameter int                X_START   = 160,
  parameter int                Y_MAX     = 100,
  parameter int                STEP      = 1,
  parameter int                TICK_DIV  = 833333,
  parameter int                SPAWN_GAP = 40,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h094
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  obstacle_scroller_if.master  draw,
  output logic [N_OBJ-1:0]     active,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int ID_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             pending;
  logic             pend_clr;

  logic [N_OBJ-1:0][X_W-1:0] x_q;
  logic [N_OBJ-1:0][Y_W-1:0] y_q;
  logic [ID_W-1:0]           idx;
  logic [GAP_W-1:0]          spawn_cnt;

  logic [Y_W-1:0]  rnd;
  logic [Y_W-1:0]  sp_y;
  logic            free_any;
  logic [ID_W-1:0] free_idx;
  logic            last_slot;

  // FSM strobes into the slot datapath
  logic idx_clr, idx_inc, mv_step, mv_exit, sp_take, sp_dec, req;

  draw_cmd_t cmd;

  obstacle_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (Y_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  assign sp_y = Y_W'(fold_y(32'(rnd), Y_MAX));

  // Frame tick divider: counts only while enabled, tick on the wrap cycle
  assign tick = enable && (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (enable)
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // One-deep tick queue; a tick landing on an unconsumed one is dropped
  assign pend_clr = (state == S_IDLE) && pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending && !pend_clr) || tick;
      if (tick && pending && !pend_clr)
        overrun <= 1'b1;
    end
  end

  // Lowest-numbered free slot for the next spawn
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int k = N_OBJ - 1; k >= 0; k--) begin
      if (!active[k]) begin
        free_any = 1'b1;
        free_idx = ID_W'(k);
      end
    end
  end

  assign last_slot = (idx == ID_W'(N_OBJ - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and datapath strobes; requests advance only on req & ack
  always_comb begin
    state_nxt = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    mv_step   = 1'b0;
    mv_exit   = 1'b0;
    sp_take   = 1'b0;
    sp_dec    = 1'b0;
    req       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          idx_clr   = 1'b1;
          state_nxt = S_ERASE;
        end
      end
      S_ERASE: begin
        if (!active[idx]) begin
          state_nxt = S_NEXT;
        end else begin
          req = 1'b1;
          if (draw.draw_ack)
            state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        // Objects that cannot take a full step leave without a redraw
        if (x_q[idx] < X_W'(STEP)) begin
          mv_exit   = 1'b1;
          state_nxt = S_NEXT;
        end else begin
          mv_step   = 1'b1;
          state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        req = 1'b1;
        if (draw.draw_ack)
          state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (last_slot) begin
          state_nxt = S_SPAWN;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = S_ERASE;
        end
      end
      S_SPAWN: begin
        // An expired counter with no free slot stays at zero and retries
        if (spawn_cnt != '0) begin
          sp_dec    = 1'b1;
          state_nxt = S_DONE;
        end else if (free_any) begin
          sp_take   = 1'b1;
          state_nxt = S_SPDRAW;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_SPDRAW: begin
        req = 1'b1;
        if (draw.draw_ack)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot table, slot pointer and spawn gap counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      active    <= '0;
      spawn_cnt <= '0;
    end else begin
      if (idx_clr)
        idx <= '0;
      else if (idx_inc)
        idx <= idx + 1'b1;
      else if (sp_take)
        idx <= free_idx;

      if (mv_step)
        x_q[idx] <= x_q[idx] - X_W'(STEP);
      if (mv_exit)
        active[idx] <= 1'b0;

      if (sp_take) begin
        x_q[free_idx]    <= X_W'(X_START);
        y_q[free_idx]    <= sp_y;
        active[free_idx] <= 1'b1;
        spawn_cnt        <= GAP_W'(SPAWN_GAP - 1);
      end else if (sp_dec) begin
        spawn_cnt <= spawn_cnt - 1'b1;
      end
    end
  end

  // Command fields follow the current slot; they only change between
  // requests, so they hold steady for as long as the drawer stalls.
  always_comb begin
    cmd       = '0;
    cmd.x     = CMD_X_W'(x_q[idx]);
    cmd.y     = CMD_Y_W'(y_q[idx]);
    cmd.erase = (state == S_ERASE);
    cmd.id    = CMD_ID_W'(idx);
  end

  assign draw.draw_req   = req;
  assign draw.draw_x     = X_W'(cmd.x);
  assign draw.draw_y     = Y_W'(cmd.y);
  assign draw.draw_erase = cmd.erase;
  assign draw.draw_id    = ID_W'(cmd.id);

  assign frame_done = (state == S_DONE);

endmodule
